// File: rtl/nou_retire_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nou_retire_pkg
//  Description : Shared constants and types for the NOU response-retire
//                controller: datapath select codes, unit index encoding and
//                the default RPU starvation-guard limit.
//  Revision    : 1.0  initial release
// ============================================================================
package nou_retire_pkg;

    // Datapath source select codes driven on or_sel.
    localparam logic [2:0] GRANT_IRUR = 3'd0;
    localparam logic [2:0] GRANT_BURR = 3'd1;
    localparam logic [2:0] GRANT_PWUR = 3'd2;
    localparam logic [2:0] GRANT_SPUR = 3'd3;
    localparam logic [2:0] GRANT_RPU  = 3'd4;
    localparam logic [2:0] GRANT_IDLE = 3'd7;

    // Unit responder index; also the round-robin search order.
    typedef enum logic [1:0] {
        UNIT_IRUR = 2'd0,
        UNIT_BURR = 2'd1,
        UNIT_PWUR = 2'd2,
        UNIT_SPUR = 2'd3
    } unit_idx_e;

    // Default number of back-to-back RPU grants tolerated while units wait.
    localparam int RPU_MAX_STREAK_DEF = 4;

endpackage : nou_retire_pkg
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4
//  Description : Combinational 4-way round-robin picker. The search starts
//                one position after the last winner and wraps.
//  Ports       : i_req[3:0]   request vector (bit n = unit index n)
//                i_rr_ptr     index of the last unit granted
//                o_gnt[3:0]   one-hot grant (all zero when no request)
//                o_idx        encoded winner index
//                o_valid      at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_rr_ptr,
    output logic [3:0] o_gnt,
    output logic [1:0] o_idx,
    output logic       o_valid
);

    // Offsets 1..4 from the pointer; offset 4 wraps back onto the last
    // winner so it is considered only when nothing else is requesting.
    always_comb begin
        o_gnt   = 4'b0000;
        o_idx   = i_rr_ptr;
        o_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!o_valid && i_req[i_rr_ptr + 2'(i)]) begin
                o_valid                  = 1'b1;
                o_idx                    = i_rr_ptr + 2'(i);
                o_gnt[i_rr_ptr + 2'(i)]  = 1'b1;
            end
        end
    end

endmodule : rr_arb4
`default_nettype wire

// File: rtl/retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : retire_ctrl
//  Description : Retire arbiter and flow-control sequencer. Grants at most one
//                of five retire requests per cycle (RPU priority with a
//                starvation guard, units round-robin), drives the datapath
//                select and the RV response FIFO push, and tracks free FIFO
//                entries with a credit counter.
//  Ports       : clk, rst                  clock, sync active-high reset
//                *_req / *_ack             per-source request / grant
//                rsp_fifo_pop              RV side consumed one entry
//                or_sel[2:0]               datapath select (7 = idle)
//                rsp_fifo_wr               FIFO push strobe
//                credit_cnt[CRD_W-1:0]     free FIFO entries
//                credit_err                sticky pop-while-empty flag
//                retire_idle               nothing pending, FIFO empty
//  Revision    : 1.0  initial release
// ============================================================================
module retire_ctrl
    import nou_retire_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int CRD_W          = $clog2(FIFO_DEPTH + 1),
    parameter int RPU_MAX_STREAK = RPU_MAX_STREAK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irur_req,
    input  logic             burr_req,
    input  logic             pwur_req,
    input  logic             spur_req,
    input  logic             rpu_req,
    output logic             irur_ack,
    output logic             burr_ack,
    output logic             pwur_ack,
    output logic             spur_ack,
    output logic             rpu_ack,
    input  logic             rsp_fifo_pop,
    output logic [2:0]       or_sel,
    output logic             rsp_fifo_wr,
    output logic [CRD_W-1:0] credit_cnt,
    output logic             credit_err,
    output logic             retire_idle
);

    localparam int               STREAK_W        = (RPU_MAX_STREAK < 1) ? 1 : $clog2(RPU_MAX_STREAK + 1);
    localparam logic [CRD_W-1:0] C_FULL_CREDIT   = CRD_W'(FIFO_DEPTH);
    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(RPU_MAX_STREAK);

    logic [CRD_W-1:0]    r_credit_cnt;
    logic                r_credit_err;
    unit_idx_e           r_rr_ptr;
    logic [STREAK_W-1:0] r_rpu_streak;

    logic [3:0] w_unit_req;
    logic       w_any_unit;
    logic [3:0] w_arb_gnt;
    logic [1:0] w_arb_idx;
    logic       w_arb_valid;
    logic       w_grant_en;
    logic       w_rpu_blocked;
    logic       w_rpu_win;
    logic       w_unit_win;
    logic       w_push;
    logic       w_credit_full;

    assign w_unit_req = {spur_req, pwur_req, burr_req, irur_req};
    assign w_any_unit = |w_unit_req;

    rr_arb4 u_rr_arb4 (
        .i_req    (w_unit_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_idx    (w_arb_idx),
        .o_valid  (w_arb_valid)
    );

    // Grants need registered credit; a same-cycle pop does not bypass.
    // Reset suppresses any grant in the cycle it is asserted.
    assign w_grant_en    = !rst && (r_credit_cnt != '0);
    assign w_credit_full = (r_credit_cnt == C_FULL_CREDIT);

    // After RPU_MAX_STREAK back-to-back RPU wins with units waiting, yield
    // one slot to the units.
    assign w_rpu_blocked = (r_rpu_streak >= C_STREAK_MAX) && w_any_unit;
    assign w_rpu_win     = w_grant_en && rpu_req && !w_rpu_blocked;
    assign w_unit_win    = w_grant_en && !w_rpu_win && w_arb_valid;
    assign w_push        = w_rpu_win || w_unit_win;

    assign irur_ack    = w_unit_win && w_arb_gnt[0];
    assign burr_ack    = w_unit_win && w_arb_gnt[1];
    assign pwur_ack    = w_unit_win && w_arb_gnt[2];
    assign spur_ack    = w_unit_win && w_arb_gnt[3];
    assign rpu_ack     = w_rpu_win;
    assign rsp_fifo_wr = w_push;

    always_comb begin
        or_sel = GRANT_IDLE;
        if (w_rpu_win) begin
            or_sel = GRANT_RPU;
        end else if (w_unit_win) begin
            or_sel = {1'b0, w_arb_idx};
        end
    end

    assign credit_cnt  = r_credit_cnt;
    assign credit_err  = r_credit_err;
    assign retire_idle = !w_any_unit && !rpu_req && w_credit_full;

    // Credit counter: push consumes an entry, pop returns one. A pop with
    // the counter already full is a protocol error from the RV side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit_cnt <= C_FULL_CREDIT;
            r_credit_err <= 1'b0;
        end else begin
            if (rsp_fifo_pop && w_credit_full) begin
                r_credit_err <= 1'b1;
            end
            if (w_push && !rsp_fifo_pop) begin
                r_credit_cnt <= r_credit_cnt - 1'b1;
            end else if (rsp_fifo_pop && !w_push && !w_credit_full) begin
                r_credit_cnt <= r_credit_cnt + 1'b1;
            end
        end
    end

    // Round-robin pointer and RPU streak counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= UNIT_SPUR;
            r_rpu_streak <= '0;
        end else begin
            if (w_unit_win) begin
                r_rr_ptr <= unit_idx_e'(w_arb_idx);
            end
            if (w_unit_win || !w_any_unit) begin
                r_rpu_streak <= '0;
            end else if (w_rpu_win && (r_rpu_streak != C_STREAK_MAX)) begin
                r_rpu_streak <= r_rpu_streak + 1'b1;
            end
        end
    end

endmodule : retire_ctrl
`default_nettype wire

// File: tb/tb_retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_retire_ctrl
//  Description : Self-checking bench for retire_ctrl. Directed scenarios
//                followed by randomized request/pop traffic, all compared
//                against a behavioural model of the retire rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_retire_ctrl;

    localparam int DEPTH  = 8;
    localparam int STREAK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       irur_req, burr_req, pwur_req, spur_req, rpu_req;
    logic       irur_ack, burr_ack, pwur_ack, spur_ack, rpu_ack;
    logic       rsp_fifo_pop;
    logic [2:0] or_sel;
    logic       rsp_fifo_wr;
    logic [3:0] credit_cnt;
    logic       credit_err;
    logic       retire_idle;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_credit;
    int m_last;
    int m_streak;
    bit m_err;

    always #5 clk = ~clk;

    retire_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .RPU_MAX_STREAK (STREAK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irur_req     (irur_req),
        .burr_req     (burr_req),
        .pwur_req     (pwur_req),
        .spur_req     (spur_req),
        .rpu_req      (rpu_req),
        .irur_ack     (irur_ack),
        .burr_ack     (burr_ack),
        .pwur_ack     (pwur_ack),
        .spur_ack     (spur_ack),
        .rpu_ack      (rpu_ack),
        .rsp_fifo_pop (rsp_fifo_pop),
        .or_sel       (or_sel),
        .rsp_fifo_wr  (rsp_fifo_wr),
        .credit_cnt   (credit_cnt),
        .credit_err   (credit_err),
        .retire_idle  (retire_idle)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Winner from the retire rules: -1 none, 0..3 unit index, 4 RPU.
    function automatic int model_winner(input logic [4:0] rq, input bit r);
        bit any_unit;
        int u;
        any_unit = (rq[3:0] != 4'b0);
        if (r || m_credit == 0) return -1;
        if (rq[4] && !(m_streak >= STREAK && any_unit)) return 4;
        for (int k = 1; k <= 4; k++) begin
            u = (m_last + k) % 4;
            if (rq[u]) return u;
        end
        return -1;
    endfunction

    // One cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic [4:0] rq, input bit pop, input bit r,
                        output int win, output logic [2:0] sel_obs);
        bit push;
        bit any_unit;
        {rpu_req, spur_req, pwur_req, burr_req, irur_req} = rq;
        rsp_fifo_pop = pop;
        rst          = r;
        #1;
        win      = model_winner(rq, r);
        any_unit = (rq[3:0] != 4'b0);
        check_eq("acks", {27'd0, rpu_ack, spur_ack, pwur_ack, burr_ack, irur_ack},
                 (win < 0) ? 32'd0 : (32'd1 << win));
        check_eq("or_sel", or_sel, (win < 0) ? 32'd7 : win);
        check_eq("fifo_wr", rsp_fifo_wr, (win >= 0) ? 32'd1 : 32'd0);
        check_eq("credit_cnt", credit_cnt, m_credit);
        check_eq("credit_err", credit_err, m_err);
        check_eq("retire_idle", retire_idle, (rq == 5'b0 && m_credit == DEPTH) ? 32'd1 : 32'd0);
        sel_obs = or_sel;
        @(posedge clk);
        if (r) begin
            m_credit = DEPTH; m_last = 3; m_streak = 0; m_err = 0;
        end else begin
            push = (win >= 0);
            if (pop && m_credit == DEPTH) m_err = 1;
            if (push && !pop) m_credit--;
            else if (pop && !push && m_credit < DEPTH) m_credit++;
            if (win >= 0 && win < 4) begin
                m_streak = 0;
                m_last   = win;
            end else if (!any_unit) begin
                m_streak = 0;
            end else if (win == 4) begin
                m_streak++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         win;
        logic [2:0] sel;
        logic [4:0] rq;
        bit         pop;
        bit         r;
        int         exp_ord[10] = '{4, 4, 4, 4, 0, 4, 4, 4, 7, 7};

        rst = 1'b1;
        {rpu_req, spur_req, pwur_req, burr_req, irur_req} = 5'b0;
        rsp_fifo_pop = 1'b0;
        @(posedge clk);
        m_credit = DEPTH; m_last = 3; m_streak = 0; m_err = 0;
        @(negedge clk);

        // Reset state
        step(5'b0, 1'b0, 1'b1, win, sel);
        check_eq("rst_credit", credit_cnt, DEPTH);
        check_eq("rst_idle", retire_idle, 1);

        // All five requests held, no pops: RPU x4, IRUR, RPU x3, then stall
        for (int i = 0; i < 10; i++) begin
            step(5'b11111, 1'b0, 1'b0, win, sel);
            check_eq("s1_order", sel, exp_ord[i]);
        end
        check_eq("s1_credit0", credit_cnt, 0);

        // IRUR+SPUR alternate; pop each cycle keeps credit constant
        step(5'b0, 1'b0, 1'b1, win, sel);
        step(5'b01001, 1'b0, 1'b0, win, sel);
        check_eq("s2_first", sel, 0);
        for (int i = 0; i < 6; i++) begin
            step(5'b01001, 1'b1, 1'b0, win, sel);
            check_eq("s2_alt", sel, (i % 2 == 0) ? 3 : 0);
            check_eq("s2_credit", credit_cnt, DEPTH - 1);
        end

        // Drain to zero, then pop + BURR in the same cycle: no bypass
        for (int i = 0; i < 20 && m_credit > 0; i++) step(5'b00001, 1'b0, 1'b0, win, sel);
        check_eq("s3_zero", credit_cnt, 0);
        step(5'b00010, 1'b1, 1'b0, win, sel);
        check_eq("s3_nobypass", sel, 7);
        check_eq("s3_credit1", credit_cnt, 1);
        step(5'b00010, 1'b0, 1'b0, win, sel);
        check_eq("s3_burr", sel, 1);
        check_eq("s3_credit0", credit_cnt, 0);

        // Push + pop at 3 holds; pop at full sets the sticky error
        step(5'b0, 1'b0, 1'b1, win, sel);
        for (int i = 0; i < 5; i++) step(5'b00001, 1'b0, 1'b0, win, sel);
        check_eq("s4_credit3", credit_cnt, 3);
        step(5'b00001, 1'b1, 1'b0, win, sel);
        check_eq("s4_hold3", credit_cnt, 3);
        for (int i = 0; i < 10 && m_credit < DEPTH; i++) step(5'b0, 1'b1, 1'b0, win, sel);
        step(5'b0, 1'b1, 1'b0, win, sel);
        check_eq("s4_err", credit_err, 1);
        check_eq("s4_full", credit_cnt, DEPTH);
        for (int i = 0; i < 3; i++) step(5'b0, 1'b0, 1'b0, win, sel);
        check_eq("s4_sticky", credit_err, 1);

        // Reset mid-stream discards the grant and restarts round-robin
        for (int i = 0; i < 3; i++) step(5'b11111, 1'b0, 1'b0, win, sel);
        step(5'b11111, 1'b0, 1'b1, win, sel);
        check_eq("s5_rst_sel", sel, 7);
        check_eq("s5_rst_err", credit_err, 0);
        check_eq("s5_rst_credit", credit_cnt, DEPTH);
        step(5'b01111, 1'b0, 1'b0, win, sel);
        check_eq("s5_irur_first", sel, 0);

        // Randomized traffic: requests held until acked
        rq = 5'b0;
        for (int n = 0; n < 600; n++) begin
            if (m_credit < DEPTH) pop = ($urandom_range(0, 1) == 1);
            else                  pop = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(rq, pop, r, win, sel);
            if (win >= 0) rq[win] = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 5; i++) begin
                if (!rq[i] && i != win)
                    rq[i] = (i == 4) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_retire_ctrl
`default_nettype wire
